// File: rtl/lamp_pkg.sv
// lamp_pkg
// Shared definitions for the cyclic lamp monitor: one-hot colour codes of the
// R/Y/G lamp bus, the phase encoding reported to the outside world, the error
// code enumeration and small helper functions for sequence checking.
package lamp_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam logic [1:0] PHASE_NONE   = 2'd0;
  localparam logic [1:0] PHASE_RED    = 2'd1;
  localparam logic [1:0] PHASE_YELLOW = 2'd2;
  localparam logic [1:0] PHASE_GREEN  = 2'd3;

  // The numeric value of each code doubles as its bit index in err_sticky.
  typedef enum logic [1:0] {
    ERR_ILLEGAL = 2'd0,
    ERR_ORDER   = 2'd1,
    ERR_SHORT   = 2'd2,
    ERR_LONG    = 2'd3
  } err_code_e;

  // Legal successor of a colour in the R -> Y -> G -> R cycle.
  function automatic logic [2:0] next_colour(input logic [2:0] colour);
    case (colour)
      RED:     return YELLOW;
      YELLOW:  return GREEN;
      GREEN:   return RED;
      default: return RED;
    endcase
  endfunction

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == RED) || (v == YELLOW) || (v == GREEN);
  endfunction

  // The tracked colour is kept as the reported phase; this recovers the
  // bus code it stands for (PHASE_NONE maps to an impossible 000).
  function automatic logic [2:0] phase_to_colour(input logic [1:0] ph);
    case (ph)
      PHASE_RED:    return RED;
      PHASE_YELLOW: return YELLOW;
      PHASE_GREEN:  return GREEN;
      default:      return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] colour_to_phase(input logic [2:0] colour);
    case (colour)
      RED:     return PHASE_RED;
      YELLOW:  return PHASE_YELLOW;
      GREEN:   return PHASE_GREEN;
      default: return PHASE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lamp_dwell_counter.sv
// lamp_dwell_counter
// Saturating count of how many consecutive samples the current colour has
// been held. Only instantiated when CYCLIC_LAMP_MON_DWELL_CHECK_EN is defined.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   load_i        restart the count at 1 (a new colour was accepted)
//   inc_i         one more sample of the same colour
//   clr_i         drop to 0 (sequence lost); highest priority
//   at_max_o      count equals MAX_DWELL
//   below_min_o   count is below MIN_DWELL
module lamp_dwell_counter
  import lamp_pkg::*;
#(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o,
  output logic below_min_o
);

  logic [WIDTH-1:0] count_q;

  // Clear wins over load, load wins over increment; the increment sticks at
  // all-ones so a stuck lamp never wraps back into the legal window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign at_max_o    = (count_q == WIDTH'(MAX_DWELL));
  assign below_min_o = (count_q <  WIDTH'(MIN_DWELL));

endmodule

// File: rtl/cyclic_lamp_monitor.sv
// cyclic_lamp_monitor
// Receive-side checker for the one-hot R/Y/G lamp bus. Locks at the first RED,
// then checks legal codes, R->Y->G->R ordering and (optionally) dwell time,
// reporting phase, lock, error pulses/sticky flags and completed rounds.
// Configuration macro: CYCLIC_LAMP_MON_DWELL_CHECK_EN enables SHORT/LONG
// dwell checks and the dwell counter; without it any hold time is accepted.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   light        sampled lamp bus (RED=100, YELLOW=010, GREEN=001)
//   clr_err      clears err_sticky
//   locked       tracking a valid sequence
//   phase        0=none 1=RED 2=YELLOW 3=GREEN
//   err_valid    one-cycle pulse per error; err_code qualifies it
//   err_sticky   one bit per error code, held until clr_err
//   cycles       saturating count of completed R->Y->G->R rounds
module cyclic_lamp_monitor
  import lamp_pkg::*;
#(
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       light,
  input  logic             clr_err,
  output logic             locked,
  output logic [1:0]       phase,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic [3:0]       err_sticky,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [0:0] ST_ACQUIRE = 1'b0;
  localparam logic [0:0] ST_TRACK   = 1'b1;

  if (MIN_DWELL < 1 || MAX_DWELL < MIN_DWELL) begin : g_badParams
    $error("cyclic_lamp_monitor: need 1 <= MIN_DWELL <= MAX_DWELL");
  end

  logic [0:0]       state_q,    state_d;
  logic [1:0]       phase_q,    phase_d;
  logic             errValid_q, errValid_d;
  err_code_e        errCode_q,  errCode_d;
  logic [3:0]       sticky_q,   sticky_d;
  logic [CNT_W-1:0] cycles_q,   cycles_d;

  logic       hasErr;
  err_code_e  newErr;
  logic [2:0] curColour;
  logic       shortHit;
  logic       longHit;

`ifdef CYCLIC_LAMP_MON_DWELL_CHECK_EN
  localparam int unsigned DwellW = $clog2(MAX_DWELL + 2);

  logic dwellLoad, dwellInc, dwellClr;
  logic atMax, belowMin;

  lamp_dwell_counter #(
    .WIDTH     (DwellW),
    .MIN_DWELL (MIN_DWELL),
    .MAX_DWELL (MAX_DWELL)
  ) u_dwell (
    .clk         (clk),
    .rst         (rst),
    .load_i      (dwellLoad),
    .inc_i       (dwellInc),
    .clr_i       (dwellClr),
    .at_max_o    (atMax),
    .below_min_o (belowMin)
  );

  assign shortHit = belowMin;
  assign longHit  = atMax;
`else
  assign shortHit = 1'b0;
  assign longHit  = 1'b0;
`endif

  // Next-state decode. Checks are ordered so that ILLEGAL beats ORDER beats
  // SHORT beats LONG; ORDER, SHORT and LONG are mutually exclusive by branch.
  // clr_err wipes the sticky flags first so a same-cycle error survives alone.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    errValid_d = 1'b0;
    errCode_d  = errCode_q;
    sticky_d   = clr_err ? 4'b0000 : sticky_q;
    cycles_d   = cycles_q;
    hasErr     = 1'b0;
    newErr     = ERR_ILLEGAL;
    curColour  = phase_to_colour(phase_q);
`ifdef CYCLIC_LAMP_MON_DWELL_CHECK_EN
    dwellLoad  = 1'b0;
    dwellInc   = 1'b0;
    dwellClr   = 1'b0;
`endif

    if (!is_onehot3(light)) begin
      hasErr = 1'b1;
      newErr = ERR_ILLEGAL;
    end else if (state_q == ST_ACQUIRE) begin
      if (light == RED) begin
        state_d = ST_TRACK;
        phase_d = PHASE_RED;
`ifdef CYCLIC_LAMP_MON_DWELL_CHECK_EN
        dwellLoad = 1'b1;
`endif
      end
    end else if (light == curColour) begin
      if (longHit) begin
        hasErr = 1'b1;
        newErr = ERR_LONG;
      end else begin
`ifdef CYCLIC_LAMP_MON_DWELL_CHECK_EN
        dwellInc = 1'b1;
`endif
      end
    end else if (light == next_colour(curColour)) begin
      if (shortHit) begin
        hasErr = 1'b1;
        newErr = ERR_SHORT;
      end else begin
        phase_d = colour_to_phase(light);
`ifdef CYCLIC_LAMP_MON_DWELL_CHECK_EN
        dwellLoad = 1'b1;
`endif
        if ((curColour == GREEN) && (cycles_q != '1)) begin
          cycles_d = cycles_q + 1'b1;
        end
      end
    end else begin
      hasErr = 1'b1;
      newErr = ERR_ORDER;
    end

    // Any error drops lock and discards the offending sample; the round
    // counter is deliberately left alone.
    if (hasErr) begin
      errValid_d       = 1'b1;
      errCode_d        = newErr;
      sticky_d[newErr] = 1'b1;
      state_d          = ST_ACQUIRE;
      phase_d          = PHASE_NONE;
`ifdef CYCLIC_LAMP_MON_DWELL_CHECK_EN
      dwellLoad        = 1'b0;
      dwellInc         = 1'b0;
      dwellClr         = 1'b1;
`endif
    end

`ifndef CYCLIC_LAMP_MON_DWELL_CHECK_EN
    sticky_d[3:2] = 2'b00;
`endif
  end

  // All reported values come straight from these registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ACQUIRE;
      phase_q    <= PHASE_NONE;
      errValid_q <= 1'b0;
      errCode_q  <= ERR_ILLEGAL;
      sticky_q   <= 4'b0000;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      errValid_q <= errValid_d;
      errCode_q  <= errCode_d;
      sticky_q   <= sticky_d;
      cycles_q   <= cycles_d;
    end
  end

  assign locked     = (state_q == ST_TRACK);
  assign phase      = phase_q;
  assign err_valid  = errValid_q;
  assign err_code   = errCode_q;
  assign err_sticky = sticky_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_cyclic_lamp_monitor.sv
// tb_cyclic_lamp_monitor
// Directed bench for cyclic_lamp_monitor. Instance A uses the default
// parameters; instance B uses MIN_DWELL=2, MAX_DWELL=3 and is exercised with
// dwell-violation vectors when CYCLIC_LAMP_MON_DWELL_CHECK_EN is defined and
// with long holds otherwise.
module tb_cyclic_lamp_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] lightA, lightB;
  logic       clrA, clrB;

  logic       lockedA, errValidA;
  logic [1:0] phaseA, errCodeA;
  logic [3:0] stickyA;
  logic [7:0] cyclesA;
  logic       lockedB, errValidB;
  logic [1:0] phaseB, errCodeB;
  logic [3:0] stickyB;
  logic [7:0] cyclesB;

  int checks   = 0;
  int failures = 0;

  cyclic_lamp_monitor dutA (
    .clk(clk), .rst(rst), .light(lightA), .clr_err(clrA),
    .locked(lockedA), .phase(phaseA), .err_valid(errValidA),
    .err_code(errCodeA), .err_sticky(stickyA), .cycles(cyclesA)
  );

  cyclic_lamp_monitor #(.MIN_DWELL(2), .MAX_DWELL(3), .CNT_W(8)) dutB (
    .clk(clk), .rst(rst), .light(lightB), .clr_err(clrB),
    .locked(lockedB), .phase(phaseB), .err_valid(errValidB),
    .err_code(errCodeB), .err_sticky(stickyB), .cycles(cyclesB)
  );

  always #5 clk = ~clk;

  // Drive one sample, let the rising edge take it, look 1 ns later.
  task automatic stepA(input logic [2:0] l, input logic c);
    lightA = l;
    clrA   = c;
    @(posedge clk);
    #1;
    clrA = 1'b0;
  endtask

  task automatic stepB(input logic [2:0] l, input logic c);
    lightB = l;
    clrB   = c;
    @(posedge clk);
    #1;
    clrB = 1'b0;
  endtask

  // Pulse reset well clear of any clock edge.
  task automatic doReset;
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    lightA = Y; lightB = Y; clrA = 1'b0; clrB = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({lockedA, phaseA, errValidA, errCodeA, stickyA, cyclesA} !== 19'd0) begin
      failures++;
      $display("[TB] FAIL reset_A: got %b/%0d/%b/%0d/%b/%0d required all zero",
               lockedA, phaseA, errValidA, errCodeA, stickyA, cyclesA);
    end
    checks++;
    if ({lockedB, phaseB, errValidB, errCodeB, stickyB, cyclesB} !== 19'd0) begin
      failures++;
      $display("[TB] FAIL reset_B: got %b/%0d/%b/%0d/%b/%0d required all zero",
               lockedB, phaseB, errValidB, errCodeB, stickyB, cyclesB);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequence;
    logic [2:0] seq   [9];
    logic [1:0] expPh [9];
    logic       expLk [9];
    logic [7:0] expCy [9];
    seq   = '{G, Y, R, Y, G, R, Y, G, R};
    expPh = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
    expLk = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    expCy = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
    for (int i = 0; i < 9; i++) begin
      stepA(seq[i], 1'b0);
      checks++;
      if (lockedA !== expLk[i]) begin
        failures++;
        $display("[TB] FAIL seq_locked[%0d]: got %b required %b", i, lockedA, expLk[i]);
      end
      checks++;
      if (phaseA !== expPh[i]) begin
        failures++;
        $display("[TB] FAIL seq_phase[%0d]: got %0d required %0d", i, phaseA, expPh[i]);
      end
      checks++;
      if (cyclesA !== expCy[i]) begin
        failures++;
        $display("[TB] FAIL seq_cycles[%0d]: got %0d required %0d", i, cyclesA, expCy[i]);
      end
      checks++;
      if (errValidA !== 1'b0) begin
        failures++;
        $display("[TB] FAIL seq_err_valid[%0d]: got %b required 0", i, errValidA);
      end
    end
  endtask

  task automatic test_order;
    doReset();
    stepA(R, 1'b0);
    checks++;
    if ({lockedA, phaseA} !== 3'b1_01) begin
      failures++;
      $display("[TB] FAIL order_lock: got locked=%b phase=%0d required 1/1", lockedA, phaseA);
    end
    stepA(G, 1'b0);
    checks++;
    if ({errValidA, errCodeA, stickyA, lockedA, phaseA} !== {1'b1, 2'd1, 4'b0010, 1'b0, 2'd0}) begin
      failures++;
      $display("[TB] FAIL order_err: got ev=%b code=%0d sticky=%b locked=%b phase=%0d required 1/1/0010/0/0",
               errValidA, errCodeA, stickyA, lockedA, phaseA);
    end
    stepA(R, 1'b0);
    checks++;
    if ({lockedA, phaseA, errValidA, errCodeA} !== {1'b1, 2'd1, 1'b0, 2'd1}) begin
      failures++;
      $display("[TB] FAIL order_relock: got locked=%b phase=%0d ev=%b code=%0d required 1/1/0/1",
               lockedA, phaseA, errValidA, errCodeA);
    end
  endtask

  task automatic test_illegal;
    stepA(3'b110, 1'b0);
    checks++;
    if ({errValidA, errCodeA, stickyA, lockedA} !== {1'b1, 2'd0, 4'b0011, 1'b0}) begin
      failures++;
      $display("[TB] FAIL illegal_track: got ev=%b code=%0d sticky=%b locked=%b required 1/0/0011/0",
               errValidA, errCodeA, stickyA, lockedA);
    end
    stepA(3'b000, 1'b0);
    checks++;
    if ({errValidA, errCodeA, lockedA, phaseA} !== {1'b1, 2'd0, 1'b0, 2'd0}) begin
      failures++;
      $display("[TB] FAIL illegal_acquire: got ev=%b code=%0d locked=%b phase=%0d required 1/0/0/0",
               errValidA, errCodeA, lockedA, phaseA);
    end
    stepA(Y, 1'b0);
    checks++;
    if ({errValidA, lockedA, phaseA} !== 4'b0_0_00) begin
      failures++;
      $display("[TB] FAIL acquire_ignore_Y: got ev=%b locked=%b phase=%0d required 0/0/0",
               errValidA, lockedA, phaseA);
    end
  endtask

  task automatic test_clr_and_reset;
    stepA(Y, 1'b1);
    checks++;
    if (stickyA !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL clr_only: got sticky=%b required 0000", stickyA);
    end
    stepA(R, 1'b0);
    stepA(G, 1'b0);
    stepA(R, 1'b0);
    checks++;
    if ({lockedA, stickyA} !== {1'b1, 4'b0010}) begin
      failures++;
      $display("[TB] FAIL clr_setup: got locked=%b sticky=%b required 1/0010", lockedA, stickyA);
    end
    stepA(3'b111, 1'b1);
    checks++;
    if ({errValidA, errCodeA, stickyA, lockedA} !== {1'b1, 2'd0, 4'b0001, 1'b0}) begin
      failures++;
      $display("[TB] FAIL clr_with_err: got ev=%b code=%0d sticky=%b locked=%b required 1/0/0001/0",
               errValidA, errCodeA, stickyA, lockedA);
    end
    stepA(R, 1'b0);
    stepA(Y, 1'b0);
    stepA(G, 1'b0);
    stepA(R, 1'b0);
    checks++;
    if ({cyclesA, phaseA} !== {8'd1, 2'd1}) begin
      failures++;
      $display("[TB] FAIL round_count: got cycles=%0d phase=%0d required 1/1", cyclesA, phaseA);
    end
    stepA(G, 1'b0);
    checks++;
    if ({errValidA, errCodeA, cyclesA, lockedA} !== {1'b1, 2'd1, 8'd1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL err_keeps_cycles: got ev=%b code=%0d cycles=%0d locked=%b required 1/1/1/0",
               errValidA, errCodeA, cyclesA, lockedA);
    end
    stepA(R, 1'b0);
    stepA(Y, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({lockedA, phaseA, errValidA, errCodeA, stickyA} !== 10'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: got locked=%b phase=%0d ev=%b code=%0d sticky=%b required all zero",
               lockedA, phaseA, errValidA, errCodeA, stickyA);
    end
    checks++;
    if (cyclesA !== 8'd0) begin
      failures++;
      $display("[TB] FAIL async_reset_cycles: got %0d required 0", cyclesA);
    end
    #1;
    rst = 1'b0;
    stepA(Y, 1'b0);
    checks++;
    if ({lockedA, phaseA, errValidA} !== 4'b0_00_0) begin
      failures++;
      $display("[TB] FAIL post_reset_acquire: got locked=%b phase=%0d ev=%b required 0/0/0",
               lockedA, phaseA, errValidA);
    end
  endtask

`ifdef CYCLIC_LAMP_MON_DWELL_CHECK_EN
  task automatic test_dwell;
    int errSeen;
    doReset();
    errSeen = 0;
    stepB(R, 1'b0); if (errValidB) errSeen++;
    stepB(R, 1'b0); if (errValidB) errSeen++;
    stepB(Y, 1'b0); if (errValidB) errSeen++;
    checks++;
    if ({errSeen, phaseB} !== {32'd0, 2'd2}) begin
      failures++;
      $display("[TB] FAIL dwell_legal: got errors=%0d phase=%0d required 0/2", errSeen, phaseB);
    end
    stepB(G, 1'b0);
    checks++;
    if ({errValidB, errCodeB, stickyB, lockedB} !== {1'b1, 2'd2, 4'b0100, 1'b0}) begin
      failures++;
      $display("[TB] FAIL dwell_short: got ev=%b code=%0d sticky=%b locked=%b required 1/2/0100/0",
               errValidB, errCodeB, stickyB, lockedB);
    end
    stepB(R, 1'b0);
    stepB(R, 1'b0);
    stepB(R, 1'b0);
    checks++;
    if ({errValidB, lockedB, phaseB} !== {1'b0, 1'b1, 2'd1}) begin
      failures++;
      $display("[TB] FAIL dwell_at_max: got ev=%b locked=%b phase=%0d required 0/1/1",
               errValidB, lockedB, phaseB);
    end
    stepB(R, 1'b0);
    checks++;
    if ({errValidB, errCodeB, stickyB, lockedB} !== {1'b1, 2'd3, 4'b1100, 1'b0}) begin
      failures++;
      $display("[TB] FAIL dwell_long: got ev=%b code=%0d sticky=%b locked=%b required 1/3/1100/0",
               errValidB, errCodeB, stickyB, lockedB);
    end
  endtask
`else
  task automatic test_no_dwell;
    int errSeen;
    doReset();
    errSeen = 0;
    for (int i = 0; i < 10; i++) begin
      stepB(R, 1'b0);
      if (errValidB) errSeen++;
    end
    for (int i = 0; i < 5; i++) begin
      stepB(Y, 1'b0);
      if (errValidB) errSeen++;
    end
    checks++;
    if (phaseB !== 2'd2) begin
      failures++;
      $display("[TB] FAIL hold_yellow: got phase=%0d required 2", phaseB);
    end
    stepB(G, 1'b0); if (errValidB) errSeen++;
    stepB(R, 1'b0); if (errValidB) errSeen++;
    checks++;
    if (errSeen !== 0) begin
      failures++;
      $display("[TB] FAIL hold_no_errors: got %0d errors required 0", errSeen);
    end
    checks++;
    if ({cyclesB, lockedB, phaseB, stickyB} !== {8'd1, 1'b1, 2'd1, 4'b0000}) begin
      failures++;
      $display("[TB] FAIL hold_round: got cycles=%0d locked=%b phase=%0d sticky=%b required 1/1/1/0000",
               cyclesB, lockedB, phaseB, stickyB);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_order();
    test_illegal();
    test_clr_and_reset();
`ifdef CYCLIC_LAMP_MON_DWELL_CHECK_EN
    test_dwell();
`else
    test_no_dwell();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
